// File: rtl/block_config_loader.sv
// Serial config loader: assembles one MEM_SIZE-bit word per latch block from a
// valid/ready bitstream and commits it with a one-hot, setup/hold-framed strobe.
module block_config_loader #(
  parameter int MEM_SIZE      = 16,
  parameter int NUM_BLOCKS    = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cfg_bit,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [MEM_SIZE-1:0]   config_out,
  output logic [NUM_BLOCKS-1:0] comb_set,
  output logic                  busy,
  output logic                  done
);
  localparam int BIT_W = (MEM_SIZE > 1)      ? $clog2(MEM_SIZE)      : 1;
  localparam int BLK_W = (NUM_BLOCKS > 1)    ? $clog2(NUM_BLOCKS)    : 1;
  localparam int STB_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, SETUP, STROBE, HOLD, DONE} state_t;

  state_t                state, state_nxt;
  logic [MEM_SIZE-1:0]   shreg, word;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BLK_W-1:0]      blk;
  logic [STB_W-1:0]      stb_cnt;
  logic [NUM_BLOCKS-1:0] set_nxt;
  logic                  xfer, last_bit, last_blk, stb_end;

  assign xfer     = cfg_valid && cfg_ready;
  assign last_bit = (bit_cnt == BIT_W'(MEM_SIZE - 1));
  assign last_blk = (blk == BLK_W'(NUM_BLOCKS - 1));
  assign stb_end  = (stb_cnt == STB_W'(STROBE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (xfer && last_bit) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (stb_end) state_nxt = HOLD;
      HOLD:    state_nxt = last_blk ? DONE : SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == SHIFT);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Completed word includes the bit being transferred on the final shift.
  always_comb begin
    word          = shreg;
    word[bit_cnt] = cfg_bit;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      blk        <= '0;
      stb_cnt    <= '0;
      config_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bit_cnt <= '0;
          blk     <= '0;
        end
        SHIFT: if (xfer) begin
          shreg <= word;
          if (last_bit) config_out <= word;
          else          bit_cnt    <= bit_cnt + 1'b1;
        end
        SETUP:  stb_cnt <= '0;
        STROBE: stb_cnt <= stb_cnt + 1'b1;
        HOLD: if (!last_blk) begin
          blk     <= blk + 1'b1;
          bit_cnt <= '0;
        end
        default: ;
      endcase
    end

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_lane
    assign set_nxt[i] = (blk == BLK_W'(i));
  end

  // Registered strobe: opens one cycle after SETUP, closes before HOLD.
  always_ff @(posedge clk or posedge rst)
    if (rst) comb_set <= '0;
    else     comb_set <= (state_nxt == STROBE) ? set_nxt : '0;
endmodule

// File: tb/tb_block_config_loader.sv
// Randomized bench for block_config_loader against a phase-level load model
// and a level-sensitive latch bank model.
module tb_block_config_loader;
  localparam int MEM_SIZE      = 16;
  localparam int NUM_BLOCKS    = 4;
  localparam int STROBE_CYCLES = 2;
  localparam int LOAD_CYC      = NUM_BLOCKS * (MEM_SIZE + STROBE_CYCLES + 2) + 1;

  logic clk = 1'b0;
  logic rst, start, cfg_bit, cfg_valid, cfg_ready, busy, done;
  logic [MEM_SIZE-1:0]   config_out;
  logic [NUM_BLOCKS-1:0] comb_set;
  logic [MEM_SIZE-1:0]   words   [NUM_BLOCKS];
  logic [MEM_SIZE-1:0]   latch_q [NUM_BLOCKS];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  block_config_loader #(
    .MEM_SIZE(MEM_SIZE), .NUM_BLOCKS(NUM_BLOCKS), .STROBE_CYCLES(STROBE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .config_out(config_out), .comb_set(comb_set),
    .busy(busy), .done(done)
  );

  // Transparent latch bank fed by the shared bus.
  always @(comb_set or config_out)
    for (int i = 0; i < NUM_BLOCKS; i++)
      if (comb_set[i]) latch_q[i] = config_out;

  // Model: MEM_SIZE accepted bits, then 1 setup, STROBE_CYCLES strobe, 1 hold per block.
  task automatic run_load(input int gap_mode, input int spur_blk, input int abort_blk,
                          output int done_cyc);
    int b, nb, post;
    bit in_shift, fin, spur_sent, v;
    logic [NUM_BLOCKS-1:0] exp_cs;
    done_cyc = -1; b = 0; nb = 0; post = 0; in_shift = 1; fin = 0; spur_sent = 0;
    @(negedge clk); start = 1'b1; cfg_valid = 1'b0;
    @(negedge clk);
    for (int cyc = 1; cyc <= 2000 && !fin; cyc++) begin
      start = 1'b0;
      if (in_shift) begin
        vectors++;
        if (cfg_ready !== 1'b1 || comb_set !== '0 || busy !== 1'b1 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL shift_phase cyc=%0d blk=%0d: got ready=%b set=%b busy=%b done=%b want 1 0 1 0",
                   cyc, b, cfg_ready, comb_set, busy, done);
        end
        case (gap_mode)
          0:       v = 1;
          1:       v = (b != 0) || (cyc % 2 == 1);
          default: v = ($urandom_range(0, 1) == 1);
        endcase
        cfg_valid = v;
        cfg_bit   = words[b][nb];
        if (spur_blk == b && nb == 5 && !spur_sent) begin
          start = 1'b1; spur_sent = 1;
        end
        if (v) begin
          nb++;
          if (nb == MEM_SIZE) begin in_shift = 0; post = 0; end
        end
      end else begin
        cfg_valid = ($urandom_range(0, 1) == 1);
        cfg_bit   = ($urandom_range(0, 1) == 1);
        if (post <= STROBE_CYCLES + 1) begin
          exp_cs = '0;
          if (post >= 1 && post <= STROBE_CYCLES) exp_cs[b] = 1'b1;
          vectors++;
          if (comb_set !== exp_cs || config_out !== words[b] || cfg_ready !== 1'b0 ||
              busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL commit_phase cyc=%0d blk=%0d p=%0d: got set=%b out=%h ready=%b busy=%b done=%b want set=%b out=%h 0 1 0",
                     cyc, b, post, comb_set, config_out, cfg_ready, busy, done, exp_cs, words[b]);
          end
          if (abort_blk == b && post == 1) begin
            #1 rst = 1'b1;
            #1;
            vectors++;
            if (comb_set !== '0 || config_out !== '0 || cfg_ready !== 1'b0 ||
                busy !== 1'b0 || done !== 1'b0) begin
              miscompares++;
              $display("FAIL async_reset_mid_strobe: got set=%b out=%h ready=%b busy=%b done=%b want all 0",
                       comb_set, config_out, cfg_ready, busy, done);
            end
            cfg_valid = 1'b0;
            @(negedge clk); rst = 1'b0;
            fin = 1;
          end else begin
            post++;
            if (post == STROBE_CYCLES + 2 && b != NUM_BLOCKS - 1) begin
              b++; nb = 0; in_shift = 1;
            end
          end
        end else if (post == STROBE_CYCLES + 2) begin
          vectors++;
          if (done !== 1'b1 || busy !== 1'b1 || comb_set !== '0 || cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse cyc=%0d: got done=%b busy=%b set=%b ready=%b want 1 1 0 0",
                     cyc, done, busy, comb_set, cfg_ready);
          end
          done_cyc = cyc;
          post++;
        end else begin
          vectors++;
          if (done !== 1'b0 || busy !== 1'b0 || comb_set !== '0 ||
              config_out !== words[NUM_BLOCKS-1]) begin
            miscompares++;
            $display("FAIL idle_after_done: got done=%b busy=%b set=%b out=%h want 0 0 0 %h",
                     done, busy, comb_set, config_out, words[NUM_BLOCKS-1]);
          end
          cfg_valid = 1'b0;
          fin = 1;
        end
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) begin
      vectors++; miscompares++;
      $display("FAIL load_timeout: got no completion want done within 2000 cycles");
    end
  endtask

  task automatic check_latches(input string tag);
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      vectors++;
      if (latch_q[i] !== words[i]) begin
        miscompares++;
        $display("FAIL %s latch[%0d]: got %h want %h", tag, i, latch_q[i], words[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    #2;
    vectors++;
    if (cfg_ready !== 1'b0 || comb_set !== '0 || config_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got ready=%b set=%b out=%h busy=%b done=%b want all 0",
               cfg_ready, comb_set, config_out, busy, done);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_during_reset: got busy=%b ready=%b want 0 0", busy, cfg_ready);
    end
    rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_full_load();
    int dc;
    words[0] = 16'hA5C3; words[1] = 16'h0001; words[2] = 16'h8000; words[3] = 16'hFFFF;
    run_load(0, -1, -1, dc);
    vectors++;
    if (dc !== LOAD_CYC) begin
      miscompares++;
      $display("FAIL load_latency: got %0d want %0d", dc, LOAD_CYC);
    end
    check_latches("full_load");
  endtask

  task automatic test_backpressure();
    int dc;
    words[0] = 16'hA5C3; words[1] = 16'h5A3C; words[2] = 16'h1234; words[3] = 16'hFEDC;
    run_load(1, -1, -1, dc);
    check_latches("backpressure");
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NUM_BLOCKS; i++) words[i] = MEM_SIZE'($urandom);
      run_load(2, -1, -1, dc);
      check_latches("random_gaps");
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    for (int i = 0; i < NUM_BLOCKS; i++) words[i] = MEM_SIZE'($urandom) | 16'h0101;
    run_load(0, -1, 2, dc);
    words[0] = ~words[0];
    for (int i = 1; i < NUM_BLOCKS; i++) words[i] = MEM_SIZE'($urandom);
    run_load(0, -1, -1, dc);
    check_latches("reload_after_reset");
  endtask

  task automatic test_spurious_start();
    int dc;
    for (int i = 0; i < NUM_BLOCKS; i++) words[i] = MEM_SIZE'($urandom);
    run_load(0, 1, -1, dc);
    vectors++;
    if (dc !== LOAD_CYC) begin
      miscompares++;
      $display("FAIL spurious_start_latency: got %0d want %0d", dc, LOAD_CYC);
    end
    check_latches("spurious_start");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_reset_mid();
    test_spurious_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/block_config_loader.md
Name: block_config_loader

Overview:
- Write-side controller for a chain of `block_config_latches` instances.
- Accepts a serial configuration bitstream over a valid/ready handshake and assembles one MEM_SIZE-bit word per target block.
- Drives the shared `config_out` bus and a one-hot `comb_set` strobe per block, so each level-sensitive latch bank captures stable data.
- Sits between the off-fabric config port and the SLICEL latch blocks.

Parameters:
- MEM_SIZE, 16, bits per latch block (width of config_in on each block).
- NUM_BLOCKS, 4, number of latch blocks programmed per load; each has its own comb_set line.
- STROBE_CYCLES, 2, cycles comb_set is held high per block (>=1).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a full load; sampled only in IDLE.
- cfg_bit  input  1  serial config data, LSB of each word first, block 0 first.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_ready  output  1  loader accepts a bit this cycle (transfer = cfg_valid & cfg_ready).
- config_out  output  MEM_SIZE  word broadcast to all blocks' config_in.
- comb_set  output  NUM_BLOCKS  one-hot capture strobe; bit i drives block i.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last block has been committed.

Behaviour:
- Reset (async, immediate): state=IDLE, cfg_ready=0, comb_set=0, config_out=0, busy=0, done=0, internal shift register/bit counter/block index=0. Reset mid-strobe must drop comb_set combinationally with rst assertion.
- States: IDLE, SHIFT, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - cfg_ready=0.
  - start=1 -> SHIFT, bit_cnt=0, blk=0.
  - start in any other state is ignored.
- SHIFT:
  - cfg_ready=1.
  - On each transfer, shreg[bit_cnt]<=cfg_bit and bit_cnt++.
  - No transfer -> hold; cfg_valid gaps are allowed.
  - On the transfer with bit_cnt==MEM_SIZE-1 -> SETUP, with config_out<=completed word including that bit.
  - cfg_ready is registered state-decoded and is 0 in the cycle after the last bit.
- SETUP:
  - 1 cycle, config_out stable, comb_set=0 (data setup before the latch opens).
  - Then -> STROBE.
- STROBE:
  - comb_set = 1<<blk for exactly STROBE_CYCLES cycles (internal counter).
  - config_out unchanged.
  - Then -> HOLD.
- HOLD:
  - 1 cycle, comb_set=0, config_out still held (hold time after the latch closes).
  - If blk==NUM_BLOCKS-1 -> DONE; else blk++, bit_cnt=0 -> SHIFT.
- DONE:
  - done=1 for 1 cycle, then -> IDLE.
  - config_out retains the last word until the next load or reset.
- comb_set is registered (glitch-free), never multi-hot, and 0 outside STROBE.
- config_out changes only on entry to SETUP; it never changes while any comb_set bit is high.
- Latency with cfg_valid held high: per block MEM_SIZE+1+STROBE_CYCLES+1 cycles. Full load = NUM_BLOCKS×(MEM_SIZE+STROBE_CYCLES+2)+1 (DONE) cycles after start.
  - Defaults: 4×20+1 = 81 cycles.
- Widths: bit_cnt is clog2(MEM_SIZE) bits and blk is clog2(NUM_BLOCKS) bits (min 1). Neither wraps in normal operation; both clear explicitly.
- A bit presented with cfg_valid=1 while cfg_ready=0 is not consumed. The upstream source must hold it.

Test Plan:
- Reset values: assert rst mid-cycle with no clock edge -> all outputs 0 immediately; state IDLE; start ignored while rst=1.
- Single full load, defaults, continuous cfg_valid, words 16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF:
  - comb_set sequence 0001, 0010, 0100, 1000, each 2 cycles;
  - config_out equals the matching word during each strobe;
  - done pulses at cycle 81 after start; busy falls the same cycle done drops.
- Backpressure/gaps: cfg_valid toggled 1-0-1-0 during block 0 -> only valid cycles consume bits; assembled word still 16'hA5C3; no bit accepted during SETUP/STROBE/HOLD (cfg_ready=0 checked).
- Stability checks:
  - config_out constant from SETUP through HOLD;
  - comb_set never multi-hot; comb_set=0 in SETUP and HOLD;
  - the `block_config_latches` model captures the expected words.
- Reset mid-operation: rst asserted during block 2 STROBE -> comb_set=0 at once. A subsequent start reloads from block 0, and block 0 receives the new first word.
- Spurious start: start pulsed during SHIFT of block 1 -> no effect on blk or bit_cnt; load completes normally with a single done pulse.
